l1_req_master: RTL and testbench

//  Core-side initiator for the 8-way L1 cache request interface. Buffers load/store

---
 rtl/l1_req_pkg.sv | 26 ++
 rtl/l1_req_fifo.sv | 67 ++++++
 rtl/l1_req_master.sv | 209 ++++++++++++++++++++
 tb/tb_l1_req_master.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_req_pkg.sv
// Shared types for the L1 request master: FSM states, the buffered
// operation record, and the address/data widths of the cache interface.
package l1_req_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } req_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } op_t;

    // Word accesses only: any set bit in the two LSBs is rejected locally.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/l1_req_fifo.sv
// Small synchronous command FIFO of op_t records. The head entry is visible
// combinationally so the FSM can latch it into its operation register on pop.
module l1_req_fifo
    import l1_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  op_t                        push_op_i,
    input  logic                       pop_i,
    output op_t                        head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    op_t              mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO never writes and an empty one never reads, so pointers stay sane
    // even if a caller ignores the flags.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_op_i;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/l1_req_master.sv
// Core-side initiator for the L1 cache. Commands are queued, then issued one
// at a time as single-cycle request pulses; each produces exactly one result
// strobe carrying read data, a sticky hit flag and an error flag.
module l1_req_master
    import l1_req_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_hit,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] wdata,
    output logic              awvalid,
    output logic              wvalid,
    output logic              arvalid,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              w_hit,
    input  logic              r_hit,
    input  logic [1:0]        w_resp,
    input  logic [1:0]        r_resp,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    req_state_t        state_q,     state_d;
    op_t               op_q,        op_d;
    logic [TMO_W-1:0]  tmo_q,       tmo_d;
    logic              sticky_q,    sticky_d;
    logic [DATA_W-1:0] res_rdata_q, res_rdata_d;
    logic              res_hit_q,   res_hit_d;
    logic              res_err_q,   res_err_d;
    logic [CNT_W-1:0]  hit_cnt_q;
    logic [CNT_W-1:0]  miss_cnt_q;

    logic              fifo_push;
    logic              fifo_pop;
    op_t               fifo_head;
    op_t               cmd_op;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic              hit_inc;
    logic              miss_inc;
    logic              cur_hit;
    logic              cur_done;

    // Reads finish on rvalid alone; the upper response bits carry nothing we use.
    logic unused_inputs;
    assign unused_inputs = ^{w_resp[1], r_resp, fifo_full};

    // Ready comes from the registered occupancy, so a pop never frees a slot
    // for a push in the same cycle.
    assign cmd_ready = (fifo_count < FCNT_W'(FIFO_DEPTH));
    assign fifo_push = cmd_valid & cmd_ready;
    assign cmd_op    = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};

    l1_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (fifo_push),
        .push_op_i (cmd_op),
        .pop_i     (fifo_pop),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign cur_hit  = op_q.we ? w_hit     : r_hit;
    assign cur_done = op_q.we ? w_resp[0] : rvalid;

    // Next-state and output decode; all outputs are zero outside their owning state.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tmo_d       = tmo_q;
        sticky_d    = sticky_q;
        res_rdata_d = res_rdata_q;
        res_hit_d   = res_hit_q;
        res_err_d   = res_err_q;
        fifo_pop    = 1'b0;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        arvalid     = 1'b0;
        data_addr   = '0;
        wdata       = '0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        rsp_hit     = 1'b0;
        rsp_err     = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_head;
                    if (is_misaligned(fifo_head.addr)) begin
                        // Rejected locally; the cache never sees this request.
                        res_rdata_d = '0;
                        res_hit_d   = 1'b0;
                        res_err_d   = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                data_addr = op_q.addr;
                wdata     = op_q.wdata;
                awvalid   = op_q.we;
                wvalid    = op_q.we;
                arvalid   = ~op_q.we;
                tmo_d     = '0;
                sticky_d  = 1'b0;
                state_d   = WAIT;
            end
            WAIT: begin
                data_addr = op_q.addr;
                wdata     = op_q.wdata;
                sticky_d  = sticky_q | cur_hit;
                tmo_d     = tmo_q + TMO_W'(1);
                // Completion is checked first so it wins over a coincident expiry.
                if (cur_done) begin
                    res_rdata_d = op_q.we ? '0 : rdata;
                    res_hit_d   = sticky_q | cur_hit;
                    res_err_d   = 1'b0;
                    state_d     = DONE;
                end else if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
                    res_rdata_d = '0;
                    res_hit_d   = 1'b0;
                    res_err_d   = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_rdata = res_rdata_q;
                rsp_hit   = res_hit_q;
                rsp_err   = res_err_q;
                hit_inc   = ~res_err_q & res_hit_q;
                miss_inc  = ~res_err_q & ~res_hit_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and per-request working registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            tmo_q       <= '0;
            sticky_q    <= 1'b0;
            res_rdata_q <= '0;
            res_hit_q   <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tmo_q       <= tmo_d;
            sticky_q    <= sticky_d;
            res_rdata_q <= res_rdata_d;
            res_hit_q   <= res_hit_d;
            res_err_q   <= res_err_d;
        end
    end

    // Saturating statistics: counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_inc && (hit_cnt_q != {CNT_W{1'b1}})) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
            if (miss_inc && (miss_cnt_q != {CNT_W{1'b1}})) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_l1_req_master.sv
// Directed bench for l1_req_master with a behavioural cache responder and a
// response scoreboard filled at push time and drained on rsp_valid.
module tb_l1_req_master;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [19:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_hit;
    logic        rsp_err;
    logic [19:0] data_addr;
    logic [31:0] wdata;
    logic        awvalid;
    logic        wvalid;
    logic        arvalid;
    logic        rvalid;
    logic [31:0] rdata;
    logic        w_hit;
    logic        r_hit;
    logic [1:0]  w_resp;
    logic [1:0]  r_resp;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    l1_req_master #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_hit   (rsp_hit),
        .rsp_err   (rsp_err),
        .data_addr (data_addr),
        .wdata     (wdata),
        .awvalid   (awvalid),
        .wvalid    (wvalid),
        .arvalid   (arvalid),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .w_hit     (w_hit),
        .r_hit     (r_hit),
        .w_resp    (w_resp),
        .r_resp    (r_resp),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        hit;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert  = 0;
    int   n_fail    = 0;
    int   exp_hit   = 0;
    int   exp_miss  = 0;

    // Cache model configuration, written by the main sequence.
    bit          cache_on    = 1'b1;
    int          cache_lat   = 2;
    logic        cache_hit   = 1'b1;
    logic [31:0] cache_rdata = 32'h0;

    logic        rsp_we_s;
    logic [19:0] rsp_addr_s;

    // Cache responder: hit flag one cycle after the request pulse, completion
    // cache_lat cycles after it. Load data is cache_rdata XOR the address.
    initial begin
        w_hit  = 1'b0;
        r_hit  = 1'b0;
        w_resp = 2'b00;
        r_resp = 2'b00;
        rvalid = 1'b0;
        rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (cache_on && (awvalid || arvalid)) begin
                rsp_we_s   = awvalid;
                rsp_addr_s = data_addr;
                @(posedge clk); #1;
                if (rsp_we_s) w_hit = cache_hit;
                else          r_hit = cache_hit;
                for (int k = 1; k < cache_lat; k++) begin
                    @(posedge clk); #1;
                    w_hit = 1'b0;
                    r_hit = 1'b0;
                end
                if (rsp_we_s) begin
                    w_resp = 2'b01;
                end else begin
                    rvalid = 1'b1;
                    r_resp = 2'b01;
                    rdata  = cache_rdata ^ {12'h0, rsp_addr_s};
                end
                @(posedge clk); #1;
                w_resp = 2'b00;
                r_resp = 2'b00;
                rvalid = 1'b0;
                rdata  = 32'h0;
                w_hit  = 1'b0;
                r_hit  = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [19:0] addr, input logic [31:0] d,
                        input logic [31:0] er, input logic eh, input logic ee);
        int guard = 0;
        exp_t e;
        @(negedge clk);
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("push_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = d;
        e.rdata = er;
        e.hit   = eh;
        e.err   = ee;
        sb_q.push_back(e);
        $display("push we=%0d addr=0x%05h wdata=0x%08h exp_rdata=0x%08h exp_hit=%0d exp_err=%0d",
                 we, addr, d, er, eh, ee);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_issue(output int found);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awvalid || arvalid) begin
                found = 1;
                break;
            end
        end
        check("issue_seen", found, 1);
    endtask

    task automatic wait_rsp(input int max_cyc, output int cyc, output logic saw_pulse);
        exp_t e;
        cyc       = 0;
        saw_pulse = 1'b0;
        while (cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (awvalid || wvalid || arvalid) saw_pulse = 1'b1;
            if (rsp_valid) break;
        end
        check("rsp_valid", rsp_valid, 1);
        if (rsp_valid) begin
            n_assert++;
            assert (sb_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed unexpected response, expected none");
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                $display("rsp rdata=0x%08h hit=%0d err=%0d after %0d cycles",
                         rsp_rdata, rsp_hit, rsp_err, cyc);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_hit", rsp_hit, e.hit);
                check("rsp_err", rsp_err, e.err);
                if (!e.err) begin
                    if (e.hit) exp_hit++;
                    else       exp_miss++;
                end
                @(negedge clk);
                check("hit_cnt", hit_cnt, exp_hit);
                check("miss_cnt", miss_cnt, exp_miss);
            end
        end
    endtask

    task automatic check_quiet_outputs(input string pfx);
        check({pfx, "_rsp"}, {rsp_valid, rsp_rdata, rsp_hit, rsp_err}, 0);
        check({pfx, "_cache"}, {data_addr, wdata, awvalid, wvalid, arvalid}, 0);
        check({pfx, "_cnt"}, {hit_cnt, miss_cnt}, 0);
        check({pfx, "_ready"}, cmd_ready, 1);
    endtask

    int          found;
    int          cyc;
    logic        saw;
    logic        saw_rsp;
    logic [19:0] a;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 20'h0;
        cmd_wdata = 32'h0;
        #1;
        check_quiet_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: store hit
        cache_on  = 1'b1;
        cache_lat = 2;
        cache_hit = 1'b1;
        push(1'b1, 20'h00104, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
        wait_issue(found);
        if (found != 0) begin
            check("t1_awvalid", awvalid, 1);
            check("t1_wvalid", wvalid, 1);
            check("t1_arvalid", arvalid, 0);
            check("t1_addr", data_addr, 20'h00104);
            check("t1_wdata", wdata, 32'hDEADBEEF);
        end
        @(negedge clk);
        check("t1_pulse_len", {awvalid, wvalid}, 0);
        check("t1_addr_hold", data_addr, 20'h00104);
        wait_rsp(30, cyc, saw);
        check("t1_latency", cyc, 2);

        // 2: load miss
        cache_hit   = 1'b0;
        cache_rdata = 32'h12345678 ^ 32'h00000200;
        push(1'b0, 20'h00200, 32'h0, 32'h12345678, 1'b0, 1'b0);
        wait_issue(found);
        check("t2_arvalid", arvalid, 1);
        check("t2_awvalid", awvalid, 0);
        wait_rsp(30, cyc, saw);

        // 3: silent cache -> timeout
        cache_on = 1'b0;
        push(1'b0, 20'h00300, 32'h0, 32'h0, 1'b0, 1'b1);
        wait_issue(found);
        wait_rsp(40, cyc, saw);
        check("t3_timeout_cycles", cyc, TMO + 1);

        // 4: misaligned store, no cache pulse
        cache_on = 1'b1;
        push(1'b1, 20'h00003, 32'h1, 32'h0, 1'b0, 1'b1);
        wait_rsp(3, cyc, saw);
        check("t4_no_pulse", saw, 0);

        // 5: slow cache, five back-to-back commands against a depth-4 FIFO
        cache_lat   = 8;
        cache_hit   = 1'b1;
        cache_rdata = 32'hCAFE0000;
        for (int i = 0; i < 5; i++) begin
            a = 20'h01000 + 20'(i * 16);
            if (i[0]) push(1'b1, a, 32'h1000 + i, 32'h0, 1'b1, 1'b0);
            else      push(1'b0, a, 32'h0, cache_rdata ^ {12'h0, a}, 1'b1, 1'b0);
        end
        check("t5_full_ready", cmd_ready, 0);
        for (int i = 0; i < 5; i++) begin
            wait_rsp(40, cyc, saw);
        end
        check("t5_sb_empty", sb_q.size(), 0);

        // 6: reset during WAIT, late w_resp must be ignored
        cache_lat = 10;
        push(1'b1, 20'h02000, 32'h55, 32'h0, 1'b1, 1'b0);
        wait_issue(found);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_quiet_outputs("t6_rst");
        exp_hit  = 0;
        exp_miss = 0;
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        saw     = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
            if (awvalid || arvalid) saw = 1'b1;
        end
        check("t6_no_rsp", saw_rsp, 0);
        check("t6_no_pulse", saw, 0);
        check("t6_cnt", {hit_cnt, miss_cnt}, 0);

        // post-reset load hit still works
        cache_lat = 2;
        push(1'b0, 20'h00400, 32'h0, cache_rdata ^ 32'h00000400, 1'b1, 1'b0);
        wait_rsp(30, cyc, saw);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, assertions=%0d failures=%0d", n_assert, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
